// File: rtl/food_spawn_ctrl.sv
// Food/item spawn scheduler: round-robin between two requesters, retries random
// candidates against range and occupancy checks. Optional: SPAWN_BORDER_EXCLUDE_EN.
module food_spawn_ctrl #(
  parameter int unsigned GRID_W    = 32,
  parameter int unsigned GRID_H    = 24,
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic [1:0]         req,
  output logic [1:0]         grant,
  output logic               done,
  output logic               fail,
  output logic [COORD_W-1:0] spawn_x,
  output logic [COORD_W-1:0] spawn_y,
  input  logic [COORD_W-1:0] rnd_x,
  input  logic [COORD_W-1:0] rnd_y,
  input  logic               rnd_stb,
  output logic               occ_qvalid,
  output logic [COORD_W-1:0] occ_qx,
  output logic [COORD_W-1:0] occ_qy,
  input  logic               occ_hit,
  output logic               busy
);

  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  localparam logic [XW:0]   X_LIM   = (XW+1)'(GRID_W);
  localparam logic [YW:0]   Y_LIM   = (YW+1)'(GRID_H);
  localparam logic [TW-1:0] TRY_LIM = TW'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RND,
    QUERY,
    CHECK,
    DONE
  } state_t;

  state_t         state;
  logic [XW-1:0]  cand_x;
  logic [YW-1:0]  cand_y;
  logic [TW-1:0]  tries;
  logic           last_served;

  logic [XW-1:0]  smp_x;
  logic [YW-1:0]  smp_y;
  logic           smp_ok;
  logic [TW-1:0]  tries_inc;
  logic           budget_out;
  logic [1:0]     pick;
  logic           unused_hi;

  assign unused_hi = ^{rnd_x[COORD_W-1:XW], rnd_y[COORD_W-1:YW]};
  assign busy      = (state != IDLE);

  always_comb begin
    smp_x  = rnd_x[XW-1:0];
    smp_y  = rnd_y[YW-1:0];
    smp_ok = ({1'b0, smp_x} < X_LIM) && ({1'b0, smp_y} < Y_LIM);
`ifdef SPAWN_BORDER_EXCLUDE_EN
    if ((smp_x == '0) || ({1'b0, smp_x} == X_LIM - (XW+1)'(1)) ||
        (smp_y == '0) || ({1'b0, smp_y} == Y_LIM - (YW+1)'(1)))
      smp_ok = 1'b0;
`endif
    // tries is always below MAX_TRIES here, so the increment cannot wrap
    tries_inc  = tries + TW'(1);
    budget_out = (tries_inc == TRY_LIM);

    // last_served = 1 means requester 1 went last, so requester 0 wins a tie
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_served ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      occ_qvalid  <= 1'b0;
      spawn_x     <= '0;
      spawn_y     <= '0;
      occ_qx      <= '0;
      occ_qy      <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      tries       <= '0;
      last_served <= 1'b1;
    end else begin
      done       <= 1'b0;
      occ_qvalid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant <= pick;
            tries <= '0;
            state <= WAIT_RND;
          end
        end

        WAIT_RND: begin
          if (rnd_stb) begin
            cand_x <= smp_x;
            cand_y <= smp_y;
            if (smp_ok) begin
              occ_qvalid <= 1'b1;
              occ_qx     <= COORD_W'(smp_x);
              occ_qy     <= COORD_W'(smp_y);
              state      <= QUERY;
            end else begin
              tries <= tries_inc;
              if (budget_out) begin
                fail  <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end

        QUERY: state <= CHECK;

        CHECK: begin
          if (occ_hit) begin
            tries <= tries_inc;
            if (budget_out) begin
              fail  <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT_RND;
            end
          end else begin
            spawn_x <= COORD_W'(cand_x);
            spawn_y <= COORD_W'(cand_y);
            fail    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          grant       <= '0;
          last_served <= grant[1];
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Scoreboard bench for food_spawn_ctrl: driver pushes expected queries/results
// from a coordinate-level model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_food_spawn_ctrl;
  localparam int unsigned GRID_W    = 32;
  localparam int unsigned GRID_H    = 24;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned MAX_TRIES = 16;
  localparam int unsigned XBITS     = $clog2(GRID_W);
  localparam int unsigned YBITS     = $clog2(GRID_H);

  logic               Clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         req = 2'b00;
  logic [1:0]         grant;
  logic               done, fail, occ_qvalid, busy;
  logic [COORD_W-1:0] spawn_x, spawn_y, occ_qx, occ_qy;
  logic [COORD_W-1:0] rnd_x = '0;
  logic [COORD_W-1:0] rnd_y = '0;
  logic               rnd_stb = 1'b0;
  logic               occ_hit = 1'b0;

  always #5 Clk = ~Clk;

  food_spawn_ctrl #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_W(COORD_W), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .Clk(Clk), .reset(reset), .req(req), .grant(grant), .done(done), .fail(fail),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .rnd_x(rnd_x), .rnd_y(rnd_y),
    .rnd_stb(rnd_stb), .occ_qvalid(occ_qvalid), .occ_qx(occ_qx), .occ_qy(occ_qy),
    .occ_hit(occ_hit), .busy(busy)
  );

  typedef struct { int x; int y; } query_t;
  typedef struct { logic [1:0] grant; logic fail; int x; int y; } result_t;

  query_t  q_exp[$];
  result_t r_exp[$];
  query_t  mq;
  result_t mr;
  int checks = 0, failures = 0, qcount = 0, cyc = 0;
  bit occ_map [GRID_H][GRID_W];

  int m_last = 1;
  int m_spawn_x = 0, m_spawn_y = 0;
  int exp_fail = 0, exp_sx = 0, exp_sy = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // 0 = rejected by range, 1 = occupied, 2 = free
  function automatic int classify(int rx, int ry);
    int cx, cy;
    cx = rx % (1 << XBITS);
    cy = ry % (1 << YBITS);
    if (cx >= int'(GRID_W) || cy >= int'(GRID_H)) return 0;
`ifdef SPAWN_BORDER_EXCLUDE_EN
    if (cx == 0 || cx == int'(GRID_W) - 1 || cy == 0 || cy == int'(GRID_H) - 1) return 0;
`endif
    return occ_map[cy][cx] ? 1 : 2;
  endfunction

  // occupancy map responder; occ_hit carries noise outside the answer cycle
  bit pend_v = 0, pend_h = 0;
  always @(negedge Clk) begin
    if (!reset && occ_qvalid) begin
      pend_v = 1;
      pend_h = (occ_qx < COORD_W'(GRID_W) && occ_qy < COORD_W'(GRID_H)) ?
               occ_map[occ_qy][occ_qx] : 1'b0;
    end
  end
  always @(posedge Clk) begin
    #1;
    if (pend_v) begin
      occ_hit = pend_h;
      pend_v  = 0;
    end else begin
      occ_hit = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge Clk) begin
    if (reset) begin
      exp_fail = 0; exp_sx = 0; exp_sy = 0;
    end else begin
      if (grant != 2'b00) chk("grant_onehot", int'($onehot(grant)), 1);
      chk("busy_vs_grant", int'(busy), int'(grant != 2'b00));
      if (occ_qvalid) begin
        qcount++;
        if (q_exp.size() == 0) begin
          chk("unexpected_query", 1, 0);
        end else begin
          mq = q_exp.pop_front();
          chk("occ_qx", int'(occ_qx), mq.x);
          chk("occ_qy", int'(occ_qy), mq.y);
        end
      end
      if (done) begin
        if (r_exp.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mr = r_exp.pop_front();
          chk("done_grant", int'(grant), int'(mr.grant));
          chk("done_fail", int'(fail), int'(mr.fail));
          chk("spawn_x", int'(spawn_x), mr.x);
          chk("spawn_y", int'(spawn_y), mr.y);
          exp_fail = int'(mr.fail); exp_sx = mr.x; exp_sy = mr.y;
        end
      end else begin
        chk("fail_hold", int'(fail), exp_fail);
        chk("spawn_x_hold", int'(spawn_x), exp_sx);
        chk("spawn_y_hold", int'(spawn_y), exp_sy);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req = 2'b00;
    repeat (n) step();
  endtask

  task automatic fill_map(input int pct);
    for (int unsigned y = 0; y < GRID_H; y++)
      for (int unsigned x = 0; x < GRID_W; x++)
        occ_map[y][x] = ($urandom_range(0, 99) < pct);
  endtask

  // Called in a cycle where the DUT is IDLE; returns in the following IDLE cycle
  // with req still driven, so a held request is re-sampled.
  task automatic serve(input logic [1:0] pat, input int cx_q[$], input int cy_q[$],
                       input bit rnd_mode, output int latency);
    int tries, idx, start, k, cls, cx, cy;
    bit fin;
    logic [1:0] g;
    query_t qe;
    result_t r;
    tries = 0; idx = 0; fin = 0; cls = 0;
    if (pat == 2'b01) g = 2'b01;
    else if (pat == 2'b10) g = 2'b10;
    else g = (m_last == 0) ? 2'b10 : 2'b01;
    req = pat;
    start = cyc;
    step();
    while (!fin) begin
      if (idx >= cx_q.size()) begin
        chk("candidates_exhausted", idx, -1);
        break;
      end
      if (rnd_mode) repeat ($urandom_range(0, 2)) step();
      rnd_x = COORD_W'(cx_q[idx]);
      rnd_y = COORD_W'(cy_q[idx]);
      rnd_stb = 1'b1;
      cls = classify(cx_q[idx], cy_q[idx]);
      cx = cx_q[idx] % (1 << XBITS);
      cy = cy_q[idx] % (1 << YBITS);
      if (cls != 0) begin
        qe.x = cx; qe.y = cy;
        q_exp.push_back(qe);
      end
      step();
      rnd_stb = 1'b0;
      if (rnd_mode && $urandom_range(0, 3) == 0) req = req ^ (~g & 2'b11);
      if (cls == 0) begin
        tries++;
        if (tries == int'(MAX_TRIES)) fin = 1;
      end else begin
        if (rnd_mode && $urandom_range(0, 1) == 1) begin
          rnd_x = COORD_W'($urandom); rnd_y = COORD_W'($urandom); rnd_stb = 1'b1;
        end
        step();
        rnd_stb = 1'b0;
        if (rnd_mode && $urandom_range(0, 1) == 1) begin
          rnd_x = COORD_W'($urandom); rnd_y = COORD_W'($urandom); rnd_stb = 1'b1;
        end
        step();
        rnd_stb = 1'b0;
        if (cls == 1) begin
          tries++;
          if (tries == int'(MAX_TRIES)) fin = 1;
        end else begin
          fin = 1;
          m_spawn_x = cx; m_spawn_y = cy;
        end
      end
      idx++;
    end
    r.grant = g; r.fail = (cls != 2); r.x = m_spawn_x; r.y = m_spawn_y;
    r_exp.push_back(r);
    k = 0;
    while (!done && k < 10) begin
      step();
      k++;
    end
    chk("done_seen", int'(done), 1);
    latency = cyc - start;
    m_last = g[1] ? 1 : 0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat, base;
    int xs[$], ys[$];
    fill_map(0);
    repeat (3) step();
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_qvalid", int'(occ_qvalid), 0);
    chk("rst_spawn_x", int'(spawn_x), 0);
    chk("rst_occ_qy", int'(occ_qy), 0);
    reset = 1'b0;
    step();

    // single request, free cell, minimum latency
    xs = '{5}; ys = '{7};
    serve(2'b01, xs, ys, 0, lat);
    chk("min_latency", lat, 4);
    idle(2);

    // range reject followed by a free cell
    xs = '{2, 2}; ys = '{30, 3};
    serve(2'b01, xs, ys, 0, lat);
    idle(1);

    // two occupied candidates, then a free one
    occ_map[4][4] = 1; occ_map[9][9] = 1;
    base = qcount;
    xs = '{4, 9, 10}; ys = '{4, 9, 1};
    serve(2'b10, xs, ys, 0, lat);
    chk("retry_queries", qcount - base, 3);
    idle(2);

    // budget exhaustion: every candidate occupied
    fill_map(100);
    xs = {}; ys = {};
    for (int i = 0; i < 20; i++) begin
      xs.push_back($urandom_range(1, GRID_W - 2));
      ys.push_back($urandom_range(1, GRID_H - 2));
    end
    base = qcount;
    serve(2'b10, xs, ys, 0, lat);
    chk("exhaust_queries", qcount - base, 16);
    idle(2);

    // round-robin with both requests held
    fill_map(0);
    xs = '{3}; ys = '{3};
    serve(2'b11, xs, ys, 0, lat);
    serve(2'b11, xs, ys, 0, lat);
    serve(2'b11, xs, ys, 0, lat);
    idle(2);

    // reset asserted during CHECK
    req = 2'b01;
    step();
    rnd_x = 10'd6; rnd_y = 10'd8; rnd_stb = 1'b1;
    mq.x = 6; mq.y = 8; q_exp.push_back(mq);
    step();
    rnd_stb = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_spawn_x", int'(spawn_x), 0);
    chk("midrst_occ_qx", int'(occ_qx), 0);
    req = 2'b00;
    m_last = 1; m_spawn_x = 0; m_spawn_y = 0;
    step(); step();
    reset = 1'b0;
    step();
    xs = '{3}; ys = '{4};
    serve(2'b10, xs, ys, 0, lat);
    idle(1);

    // randomized services
    for (int s = 0; s < 150; s++) begin
      int pct_sel;
      logic [1:0] pat;
      pct_sel = $urandom_range(0, 3);
      fill_map(pct_sel == 0 ? 0 : pct_sel == 1 ? 40 : pct_sel == 2 ? 85 : 100);
      pat = 2'($urandom_range(1, 3));
      xs = {}; ys = {};
      for (int i = 0; i < 40; i++) begin
        xs.push_back($urandom_range(0, 1023));
        ys.push_back($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      serve(pat, xs, ys, 1, lat);
    end
    idle(4);
    chk("query_queue_empty", q_exp.size(), 0);
    chk("result_queue_empty", r_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
